// File: rtl/trap_ctrl.sv
// trap_ctrl: resolves exceptions, mret and the machine-timer interrupt into
// a single flush/redirect sequence. The sequence is ISSUE for one cycle, then
// HOLD for HOLD_CYCLES cycles while the pipeline refills.
module trap_ctrl #(
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid,
  input  logic [31:0] exc_cause,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_tval,
  input  logic        mret_req,
  input  logic        commit_valid,
  input  logic [31:0] commit_pc,
  input  logic        timer_interrupt,
  input  logic        mie_mtie,
  input  logic        mstatus_mie,
  input  logic [1:0]  priv_mode,
  input  logic [31:0] mtvec_in,
  input  logic [31:0] mepc_in,
  output logic        trap_enter,
  output logic [31:0] trap_cause,
  output logic [31:0] trap_pc,
  output logic [31:0] trap_val,
  output logic        mret_exec,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    KIND_NONE = 2'd0,
    KIND_EXC  = 2'd1,
    KIND_INT  = 2'd2,
    KIND_MRET = 2'd3
  } kind_t;

  localparam logic [31:0] TIMER_CAUSE = 32'h8000_0007;
  localparam logic [3:0]  HOLD_INIT   = (HOLD_CYCLES == 32'd0) ? 4'd0 : 4'(HOLD_CYCLES - 32'd1);

  state_t      state_r, state_s;
  kind_t       kind_r, kind_s;
  logic [3:0]  cnt_r, cnt_s;
  logic [31:0] cause_r, cause_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] val_r, val_s;
  logic        int_take_s;
  logic        issue_s;
  logic [31:0] base_s;
  logic [31:0] rpc_s;
  logic        unused_mepc_bits_s;

  // The interrupt is only taken when enabled and an instruction is available
  // to carry it; otherwise it simply stays pending on the level input.
  assign int_take_s = timer_interrupt & mie_mtie & (mstatus_mie | (priv_mode == 2'd0)) & commit_valid;
  assign unused_mepc_bits_s = |mepc_in[1:0];

  // State, counter, event kind and latched trap values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      kind_r  <= KIND_NONE;
      cnt_r   <= 4'd0;
      cause_r <= 32'd0;
      pc_r    <= 32'd0;
      val_r   <= 32'd0;
    end else begin
      state_r <= state_s;
      kind_r  <= kind_s;
      cnt_r   <= cnt_s;
      cause_r <= cause_s;
      pc_r    <= pc_s;
      val_r   <= val_s;
    end
  end

  // Next-state logic; events are only looked at in IDLE, everything arriving
  // during ISSUE/HOLD belongs to instructions that are being flushed.
  always_comb begin
    state_s = state_r;
    kind_s  = kind_r;
    cnt_s   = cnt_r;
    cause_s = cause_r;
    pc_s    = pc_r;
    val_s   = val_r;
    case (state_r)
      ST_IDLE: begin
        if (exc_valid) begin
          state_s = ST_ISSUE;
          kind_s  = KIND_EXC;
          cause_s = exc_cause;
          pc_s    = exc_pc;
          val_s   = exc_tval;
        end else if (mret_req) begin
          state_s = ST_ISSUE;
          kind_s  = KIND_MRET;
        end else if (int_take_s) begin
          state_s = ST_ISSUE;
          kind_s  = KIND_INT;
          cause_s = TIMER_CAUSE;
          pc_s    = commit_pc;
          val_s   = 32'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (HOLD_CYCLES == 32'd0) begin
          state_s = ST_IDLE;
          cnt_s   = 4'd0;
        end else begin
          state_s = ST_HOLD;
          cnt_s   = HOLD_INIT;
        end
      end
      ST_HOLD: begin
        if (cnt_r == 4'd0) begin
          state_s = ST_IDLE;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // Redirect target, using mtvec/mepc as presented during ISSUE. Vectored
  // mode offsets only interrupts; reserved modes 2/3 behave as direct.
  always_comb begin
    base_s = {mtvec_in[31:2], 2'b00};
    rpc_s  = 32'd0;
    if (issue_s) begin
      case (kind_r)
        KIND_MRET: rpc_s = {mepc_in[31:2], 2'b00};
        KIND_INT: begin
          if (mtvec_in[1:0] == 2'b01) begin
            rpc_s = base_s + {cause_r[29:0], 2'b00};
          end else begin
            rpc_s = base_s;
          end
        end
        KIND_EXC:  rpc_s = base_s;
        default:   rpc_s = 32'd0;
      endcase
    end else begin
      rpc_s = 32'd0;
    end
  end

  assign issue_s        = (state_r == ST_ISSUE);
  assign trap_enter     = issue_s & ((kind_r == KIND_EXC) | (kind_r == KIND_INT));
  assign mret_exec      = issue_s & (kind_r == KIND_MRET);
  assign flush          = issue_s;
  assign redirect_valid = issue_s;
  assign redirect_pc    = rpc_s;
  assign trap_cause     = cause_r;
  assign trap_pc        = pc_r;
  assign trap_val       = val_r;
  assign busy           = (state_r != ST_IDLE);

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: table of single events plus hand-written
// multi-cycle sequences; pulses are matched against a scoreboard queue.
module tb_trap_ctrl;
  localparam int H = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exc_valid = 1'b0, mret_req = 1'b0, commit_valid = 1'b0;
  logic        timer_interrupt = 1'b0, mie_mtie = 1'b0, mstatus_mie = 1'b0;
  logic [1:0]  priv_mode = 2'd3;
  logic [31:0] exc_cause = 32'd0, exc_pc = 32'd0, exc_tval = 32'd0, commit_pc = 32'd0;
  logic [31:0] mtvec_in = 32'd0, mepc_in = 32'd0;
  logic        trap_enter, mret_exec, flush, redirect_valid, busy;
  logic [31:0] trap_cause, trap_pc, trap_val, redirect_pc;

  trap_ctrl #(.HOLD_CYCLES(H)) dut (
    .clk(clk), .rst(rst), .exc_valid(exc_valid), .exc_cause(exc_cause),
    .exc_pc(exc_pc), .exc_tval(exc_tval), .mret_req(mret_req),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .timer_interrupt(timer_interrupt), .mie_mtie(mie_mtie),
    .mstatus_mie(mstatus_mie), .priv_mode(priv_mode), .mtvec_in(mtvec_in),
    .mepc_in(mepc_in), .trap_enter(trap_enter), .trap_cause(trap_cause),
    .trap_pc(trap_pc), .trap_val(trap_val), .mret_exec(mret_exec),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int ncheck = 0;
  int nfail = 0;

  // cycle stamp used to check pulse latency
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    logic        te, me;
    logic [31:0] rpc, cause, pc, val;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        exc, mret, tmr, mtie, mmie, cv;
    logic [1:0]  priv;
    logic [31:0] cause, epc, tval, cpc, mtvec, mepc;
    logic        te, me;
    logic [31:0] rpc, xcause, xpc, xval;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncheck++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic te, input logic me, input logic [31:0] rpc,
                      input logic [31:0] c, input logic [31:0] p, input logic [31:0] v, input int dly);
    exp_t e;
    e.at = cyc + dly; e.te = te; e.me = me; e.rpc = rpc; e.cause = c; e.pc = p; e.val = v;
    sb.push_back(e);
  endtask

  task automatic clear_events();
    exc_valid = 1'b0; mret_req = 1'b0; timer_interrupt = 1'b0; commit_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_te"}, {31'd0, trap_enter}, 32'd0);
    chk({tag, "_me"}, {31'd0, mret_exec}, 32'd0);
    chk({tag, "_flush"}, {31'd0, flush}, 32'd0);
    chk({tag, "_rv"}, {31'd0, redirect_valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_rpc"}, redirect_pc, 32'd0);
    chk({tag, "_cause"}, trap_cause, 32'd0);
    chk({tag, "_pc"}, trap_pc, 32'd0);
    chk({tag, "_val"}, trap_val, 32'd0);
  endtask

  // Output monitor: every pulse must match the oldest scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (trap_enter || mret_exec) begin
      if (sb.size() == 0) begin
        ncheck++;
        nfail++;
        $display("FAIL unexpected_pulse: got te=%0b me=%0b expected none (cycle %0d)", trap_enter, mret_exec, cyc);
      end else begin
        e = sb.pop_front();
        chk("pulse_cycle", cyc, e.at);
        chk("trap_enter", {31'd0, trap_enter}, {31'd0, e.te});
        chk("mret_exec", {31'd0, mret_exec}, {31'd0, e.me});
        chk("flush_rv", {30'd0, flush, redirect_valid}, 32'd3);
        chk("redirect_pc", redirect_pc, e.rpc);
        chk("trap_cause", trap_cause, e.cause);
        chk("trap_pc", trap_pc, e.pc);
        chk("trap_val", trap_val, e.val);
        chk("busy_issue", {31'd0, busy}, 32'd1);
      end
    end else begin
      chk("no_flush", {30'd0, flush, redirect_valid}, 32'd0);
    end
  end

  initial begin
    //          exc  mret tmr  mtie mmie cv   priv   cause  epc        tval        cpc        mtvec           mepc          te   me   rpc             xcause         xpc        xval
    vecs[0] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd3, 32'd2, 32'h100, 32'hDEAD, 32'h0,   32'h8000_0000, 32'h0,       1'b1,1'b0,32'h8000_0000, 32'd2,         32'h100, 32'hDEAD};
    vecs[1] = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,2'd3, 32'd0, 32'h0,   32'h0,    32'h200, 32'h8000_0001, 32'h0,       1'b1,1'b0,32'h8000_001C, 32'h8000_0007, 32'h200, 32'h0};
    vecs[2] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd3, 32'd0, 32'h0,   32'h0,    32'h0,   32'h8000_0001, 32'h0000_0403,1'b0,1'b1,32'h0000_0400, 32'h8000_0007, 32'h200, 32'h0};
    vecs[3] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd3, 32'd5, 32'h300, 32'h44,   32'h0,   32'h1234_5671, 32'h0,       1'b1,1'b0,32'h1234_5670, 32'd5,         32'h300, 32'h44};
    vecs[4] = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,2'd0, 32'd0, 32'h0,   32'h0,    32'h508, 32'h0000_1003, 32'h0,       1'b1,1'b0,32'h0000_1000, 32'h8000_0007, 32'h508, 32'h0};
    vecs[5] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'd3, 32'd3, 32'h600, 32'h11,   32'h0,   32'h2000_0000, 32'h0000_0ABC,1'b1,1'b0,32'h2000_0000, 32'd3,         32'h600, 32'h11};
    vecs[6] = '{1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,2'd3, 32'd0, 32'h0,   32'h0,    32'h700, 32'h8000_0001, 32'h0000_0ABC,1'b0,1'b1,32'h0000_0ABC, 32'd3,         32'h600, 32'h11};
    vecs[7] = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,2'd3, 32'd0, 32'h0,   32'h0,    32'h7F0, 32'hFFFF_FFF1, 32'h0,       1'b1,1'b0,32'h0000_000C, 32'h8000_0007, 32'h7F0, 32'h0};
    vecs[8] = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,2'd3, 32'd0, 32'h0,   32'h0,    32'h810, 32'h0000_2002, 32'h0,       1'b1,1'b0,32'h0000_2000, 32'h8000_0007, 32'h810, 32'h0};

    // reset state
    rst = 1'b1;
    tick(); tick(); tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // table-driven single events
    for (int i = 0; i < 9; i++) begin
      exc_valid = vecs[i].exc; mret_req = vecs[i].mret; timer_interrupt = vecs[i].tmr;
      mie_mtie = vecs[i].mtie; mstatus_mie = vecs[i].mmie; commit_valid = vecs[i].cv;
      priv_mode = vecs[i].priv; exc_cause = vecs[i].cause; exc_pc = vecs[i].epc;
      exc_tval = vecs[i].tval; commit_pc = vecs[i].cpc; mtvec_in = vecs[i].mtvec;
      mepc_in = vecs[i].mepc;
      push(vecs[i].te, vecs[i].me, vecs[i].rpc, vecs[i].xcause, vecs[i].xpc, vecs[i].xval, 1);
      tick();
      clear_events();
      for (int k = 0; k < H + 1; k++) begin
        chk("busy_seq", {31'd0, busy}, 32'd1);
        tick();
      end
      chk("busy_done", {31'd0, busy}, 32'd0);
    end

    // exception and interrupt together: interrupt follows H+2 cycles later
    mtvec_in = 32'h8000_0000; mie_mtie = 1'b1; mstatus_mie = 1'b1; priv_mode = 2'd3;
    timer_interrupt = 1'b1; commit_valid = 1'b1; commit_pc = 32'h900;
    exc_valid = 1'b1; exc_cause = 32'd4; exc_pc = 32'h880; exc_tval = 32'h77;
    push(1'b1, 1'b0, 32'h8000_0000, 32'd4, 32'h880, 32'h77, 1);
    push(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0007, 32'h900, 32'h0, 1 + H + 2);
    tick();
    exc_valid = 1'b0;
    for (int k = 0; k < H + 2; k++) tick();
    clear_events();
    for (int k = 0; k < H + 2; k++) tick();

    // masking: M-mode with mstatus_mie=0 ignores, U-mode takes
    mstatus_mie = 1'b0; priv_mode = 2'd3; timer_interrupt = 1'b1; commit_valid = 1'b1;
    commit_pc = 32'hA00;
    for (int k = 0; k < 5; k++) tick();
    chk("masked_busy", {31'd0, busy}, 32'd0);
    priv_mode = 2'd0;
    push(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0007, 32'hA00, 32'h0, 1);
    tick();
    clear_events();
    for (int k = 0; k < H + 1; k++) tick();

    // commit_valid=0 defers the interrupt
    priv_mode = 2'd3; mstatus_mie = 1'b1; timer_interrupt = 1'b1; commit_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("deferred_busy", {31'd0, busy}, 32'd0);
    commit_valid = 1'b1; commit_pc = 32'hB00;
    push(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0007, 32'hB00, 32'h0, 1);
    tick();
    clear_events();
    for (int k = 0; k < H + 1; k++) tick();

    // exception held through ISSUE/HOLD yields only one pulse
    mie_mtie = 1'b0;
    exc_valid = 1'b1; exc_cause = 32'd1; exc_pc = 32'hC00; exc_tval = 32'h0;
    push(1'b1, 1'b0, 32'h8000_0000, 32'd1, 32'hC00, 32'h0, 1);
    for (int k = 0; k < H + 1; k++) tick();
    exc_valid = 1'b0;
    for (int k = 0; k < 3; k++) tick();

    // reset during ISSUE aborts; first edge with rst=0 accepts a new event
    exc_valid = 1'b1; exc_cause = 32'd6; exc_pc = 32'hD00; exc_tval = 32'h9;
    push(1'b1, 1'b0, 32'h8000_0000, 32'd6, 32'hD00, 32'h9, 1);
    tick();
    exc_valid = 1'b0; rst = 1'b1;
    tick();
    check_all_zero("midreset");
    rst = 1'b0;
    exc_valid = 1'b1; exc_cause = 32'd7; exc_pc = 32'hE00; exc_tval = 32'h5;
    push(1'b1, 1'b0, 32'h8000_0000, 32'd7, 32'hE00, 32'h5, 1);
    tick();
    exc_valid = 1'b0;
    for (int k = 0; k < H + 5; k++) tick();

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", ncheck, nfail);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 Parameter HOLD_CYCLES, default 2 (legal 0..15): number of cycles new events are ignored after a redirect, while the pipeline refills.
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 exc_valid  in  1  the oldest committing instruction raised a synchronous exception.
REQ-005 exc_cause  in  32  exception code (bit31=0).
REQ-006 exc_pc  in  32  PC of the faulting instruction.
REQ-007 exc_tval  in  32  faulting address or instruction bits.
REQ-008 mret_req  in  1  the oldest committing instruction is mret.
REQ-009 commit_valid  in  1  commit_pc holds a valid, not-yet-executed instruction.
REQ-010 commit_pc  in  32  PC of that instruction.
REQ-011 timer_interrupt  in  1  level machine-timer pending.
REQ-012 mie_mtie, mstatus_mie  in  1 each  interrupt enables from the CSR file.
REQ-013 priv_mode  in  2  current privilege level (0=U, 3=M).
REQ-014 mtvec_in, mepc_in  in  32 each  trap vector and return address from the CSR file.
REQ-015 trap_enter  out  1  one-cycle pulse to the CSR file.
REQ-016 trap_cause, trap_pc, trap_val  out  32 each  values latched for the CSR file.
REQ-017 mret_exec  out  1  one-cycle pulse to the CSR file.
REQ-018 flush  out  1  kill all in-flight instructions.
REQ-019 redirect_valid  out  1  fetch SHALL load redirect_pc.
REQ-020 redirect_pc  out  32  new fetch PC.
REQ-021 busy  out  1  high whenever the state is not IDLE.

Function
REQ-022 The FSM SHALL have three states: IDLE, ISSUE and HOLD.
REQ-023 In IDLE, events SHALL be resolved by fixed priority: exc_valid > mret_req > interrupt.
REQ-024 An interrupt SHALL be taken when timer_interrupt & mie_mtie & (mstatus_mie | priv_mode==0) & commit_valid are all true.
- An interrupt with commit_valid=0 SHALL wait.
- The interrupt is level-sensitive, so it is not lost while waiting.
REQ-025 On the resolving edge, the block SHALL latch the following and enter ISSUE:
- Exception: trap_cause=exc_cause, trap_pc=exc_pc, trap_val=exc_tval.
- Interrupt: trap_cause=32'h8000_0007, trap_pc=commit_pc, trap_val=0.
- mret: latch only the kind.
REQ-026 In ISSUE, for exactly one cycle, the block SHALL assert flush=1 and redirect_valid=1, plus trap_enter=1 (trap) or mret_exec=1 (mret).
REQ-027 redirect_pc for a trap SHALL be computed from mtvec_in sampled in ISSUE:
- Mode 0 (mtvec_in[1:0]=0): {mtvec[31:2],2'b00}.
- Mode 1 with an interrupt: {mtvec[31:2],2'b00} + 4*trap_cause[30:0], computed modulo 2^32.
- Mode 1 with an exception: the base address.
- mtvec_in[1:0] values 2 or 3: treated as mode 0.
REQ-028 redirect_pc for mret SHALL be {mepc_in[31:2],2'b00}, sampled in ISSUE.
REQ-029 From ISSUE, the FSM SHALL go to HOLD with counter=HOLD_CYCLES-1, or to IDLE if HOLD_CYCLES=0.
REQ-030 In HOLD, the counter SHALL decrement each cycle and the FSM SHALL return to IDLE on the cycle after the counter reads 0.
REQ-031 All event inputs SHALL be ignored in ISSUE and HOLD; they belong to flushed instructions.
REQ-032 Simultaneous events:
- exc_valid with mret_req: exception taken, mret discarded.
- exc_valid with an interrupt: exception taken; the interrupt remains pending and is evaluated again in IDLE.
- mret_req with an interrupt: mret taken first.
REQ-033 trap_cause, trap_pc and trap_val SHALL hold their values outside the resolving edge.
REQ-034 The block SHALL NOT emit back-to-back pulses: the minimum spacing between trap_enter/mret_exec pulses SHALL be HOLD_CYCLES+2 cycles.

Reset
REQ-035 On rst=1 at a clock edge, state SHALL become IDLE, the counter 0, and every output 0; this includes trap_cause/pc/val and redirect_pc.
REQ-036 rst asserted during ISSUE or HOLD SHALL abort the sequence; no pulse SHALL be emitted after the reset edge.
REQ-037 The first event SHALL be accepted on the first edge where rst=0.

Verification
REQ-038 Exception in mode 0:
- Stimulus: exc_valid=1, cause=2, pc=0x100, tval=0xDEAD, mtvec_in=0x8000_0000.
- Response: next cycle trap_enter=flush=redirect_valid=1, redirect_pc=0x8000_0000, trap_pc=0x100; busy high for 1+HOLD_CYCLES cycles.
REQ-039 Vectored timer interrupt:
- Stimulus: mtvec_in=0x8000_0001, timer=mtie=mstatus_mie=1, commit_valid=1, commit_pc=0x200.
- Response: trap_cause=0x8000_0007, trap_pc=0x200, redirect_pc=0x8000_001C.
REQ-040 mret:
- Stimulus: mret_req=1, mepc_in=0x0000_0403.
- Response: mret_exec=1 with trap_enter=0, redirect_pc=0x400.
REQ-041 Priority and pending interrupt:
- Stimulus: exc_valid and an enabled interrupt in the same cycle.
- Response: exception taken; the interrupt is taken HOLD_CYCLES+2 cycles later if still pending.
REQ-042 Masking:
- Stimulus: interrupt with mstatus_mie=0 and priv_mode=3 -> no action; priv_mode=0 -> taken.
- Stimulus: commit_valid=0 -> deferred until commit_valid=1.
REQ-043 Reset mid-sequence:
- Stimulus: rst during ISSUE.
- Response: all outputs 0 next cycle and no further pulses; exc_valid held during HOLD is ignored.
